// File: rtl/quad_encoder_gen_if.sv
// ---------------------------------------------------------------------------
// quad_encoder_gen_if
// Command handshake bundle for the quadrature encoder generator.
//   cmd_valid  : initiator has a command present
//   cmd_ready  : generator can accept a command (idle)
//   cmd_dir    : 1 = forward (A leads B), 0 = reverse (B leads A)
//   cmd_steps  : number of full quadrature cycles to emit (0 is legal)
// Modports:
//   master : command initiator (drives valid/dir/steps, observes ready)
//   slave  : the generator (observes valid/dir/steps, drives ready)
// ---------------------------------------------------------------------------
interface quad_encoder_gen_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_steps;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// quad_encoder_gen
// Emulated rotary quadrature encoder. Each accepted command emits
// 4*cmd_steps Gray-code transitions on enc_a/enc_b, spaced EDGE_CYCLES
// clocks apart, then pulses done for one cycle.
//
// Parameters:
//   EDGE_CYCLES : clocks between consecutive A/B transitions (2..65535)
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cmd        : command handshake (quad_encoder_gen_if.slave)
//   enc_a/b    : registered encoder channels
//   busy       : high while a command is running
//   done       : one-cycle pulse on command completion
//   pos        : position count modulo 256 (8'h00 when not built)
//
// Configuration macro:
//   QUAD_POS_EN : when defined, the 8-bit position counter is built;
//                 otherwise pos is tied to 8'h00.
// ---------------------------------------------------------------------------
module quad_encoder_gen #(
  parameter int unsigned EDGE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  quad_encoder_gen_if.slave        cmd,
  output logic                     enc_a,
  output logic                     enc_b,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               pos
);

  localparam logic [15:0] SPACE_LAST = 16'(EDGE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] remain_q, remain_d;
  logic [15:0] space_q, space_d;
  logic       dir_q, dir_d;
  logic       enc_a_q, enc_a_d;
  logic       enc_b_q, enc_b_d;
  logic       done_q, done_d;

  logic       edge_tick;
  logic       next_a;
  logic       next_b;

  assign edge_tick = (state_q == RUN) && (space_q == SPACE_LAST);

  // One Gray step: forward walks 00->10->11->01, reverse walks 00->01->11->10.
  assign next_a = dir_q ? ~enc_b_q : enc_b_q;
  assign next_b = dir_q ? enc_a_q  : ~enc_a_q;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    space_d  = space_q;
    dir_d    = dir_q;
    enc_a_d  = enc_a_q;
    enc_b_d  = enc_b_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          dir_d = cmd.cmd_dir;
          if (cmd.cmd_steps != 8'd0) begin
            state_d  = RUN;
            remain_d = {cmd.cmd_steps, 2'b00};
            space_d  = 16'd0;
          end else begin
            // Zero-length command completes without leaving IDLE.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (edge_tick) begin
          space_d  = 16'd0;
          enc_a_d  = next_a;
          enc_b_d  = next_b;
          remain_d = remain_q - 10'd1;
          // The final transition and the return to IDLE share one edge.
          if (remain_q == 10'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          space_d = space_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= 10'd0;
      space_q  <= 16'd0;
      dir_q    <= 1'b0;
      enc_a_q  <= 1'b0;
      enc_b_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      space_q  <= space_d;
      dir_q    <= dir_d;
      enc_a_q  <= enc_a_d;
      enc_b_q  <= enc_b_d;
      done_q   <= done_d;
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q == RUN);
  assign enc_a         = enc_a_q;
  assign enc_b         = enc_b_q;
  assign done          = done_q;

`ifdef QUAD_POS_EN
  logic [7:0] pos_q, pos_d;

  // A transition landing on 00 completes one full step.
  always_comb begin
    pos_d = pos_q;
    if (edge_tick && !next_a && !next_b) begin
      pos_d = dir_q ? (pos_q + 8'd1) : (pos_q - 8'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= 8'd0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;
`else
  assign pos = 8'h00;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// tb_quad_encoder_gen
// Directed bench for quad_encoder_gen with EDGE_CYCLES = 4. Inputs change
// and outputs are sampled on the falling clock edge. Expected pos follows
// QUAD_POS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_quad_encoder_gen;

  localparam int E = 4;

  logic       clk;
  logic       rst_n;
  logic       enc_a;
  logic       enc_b;
  logic       busy;
  logic       done;
  logic [7:0] pos;

  int vectors     = 0;
  int miscompares = 0;

  quad_encoder_gen_if cmd_if ();

  quad_encoder_gen #(
    .EDGE_CYCLES (E)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd_if),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .busy  (busy),
    .done  (done),
    .pos   (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pos value depending on whether the counter is built
  function automatic logic [7:0] posExp(input logic [7:0] p);
`ifdef QUAD_POS_EN
    return p;
`else
    return 8'h00;
`endif
  endfunction

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command; the handshake happens at the next rising edge
  task automatic applyStimulus(input logic dir, input logic [7:0] steps);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_steps = steps;
  endtask

  // Expected outputs c cycles after the handshake edge of an n-step command
  task automatic checkCycle(input string tag, input int c, input logic dir,
                            input int n, input logic [7:0] posStart);
    int         last;
    int         trans;
    logic [1:0] ab;
    logic [7:0] p;
    last  = 4 * n * E;
    trans = c / E;
    if (trans > 4 * n) trans = 4 * n;
    if (dir) begin
      case (trans % 4)
        0: ab = 2'b00;
        1: ab = 2'b10;
        2: ab = 2'b11;
        default: ab = 2'b01;
      endcase
      p = posStart + 8'(trans / 4);
    end else begin
      case (trans % 4)
        0: ab = 2'b00;
        1: ab = 2'b01;
        2: ab = 2'b11;
        default: ab = 2'b10;
      endcase
      p = posStart - 8'(trans / 4);
    end
    checkOutput($sformatf("%s c%0d ab", tag, c), 8'({enc_a, enc_b}), 8'(ab));
    checkOutput($sformatf("%s c%0d busy", tag, c), 8'(busy), 8'(c < last));
    checkOutput($sformatf("%s c%0d done", tag, c), 8'(done), 8'(c == last));
    checkOutput($sformatf("%s c%0d ready", tag, c), 8'(cmd_if.cmd_ready), 8'(c >= last));
    checkOutput($sformatf("%s c%0d pos", tag, c), pos, posExp(p));
  endtask

  // Follow a command from its handshake through its done cycle; optionally
  // keep cmd_valid high with the next command's fields
  task automatic monitorCommand(input string tag, input logic dir, input int n,
                                input logic [7:0] posStart, input logic holdValid,
                                input logic nDir, input logic [7:0] nSteps);
    @(negedge clk);
    if (holdValid) begin
      cmd_if.cmd_dir   = nDir;
      cmd_if.cmd_steps = nSteps;
    end else begin
      cmd_if.cmd_valid = 1'b0;
    end
    for (int c = 0; c <= 4 * n * E; c++) begin
      if (c > 0) @(negedge clk);
      checkCycle(tag, c, dir, n, posStart);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = 8'd0;

    // Reset held for three cycles, then released
    repeat (3) @(negedge clk);
    checkOutput("rst ab",    8'({enc_a, enc_b}), 8'd0);
    checkOutput("rst busy",  8'(busy), 8'd0);
    checkOutput("rst ready", 8'(cmd_if.cmd_ready), 8'd1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel ab",    8'({enc_a, enc_b}), 8'd0);
    checkOutput("rel busy",  8'(busy), 8'd0);
    checkOutput("rel done",  8'(done), 8'd0);
    checkOutput("rel pos",   pos, 8'd0);
    checkOutput("rel ready", 8'(cmd_if.cmd_ready), 8'd1);

    // One forward step
    applyStimulus(1'b1, 8'd1);
    monitorCommand("t1", 1'b1, 1, 8'd0, 1'b0, 1'b0, 8'd0);
    checkOutput("t1 pos end", pos, posExp(8'd1));
    @(negedge clk);
    checkOutput("t1 done off", 8'(done), 8'd0);

    // Three reverse steps, wrapping pos through zero
    applyStimulus(1'b0, 8'd3);
    monitorCommand("t2", 1'b0, 3, 8'd1, 1'b0, 1'b0, 8'd0);
    checkOutput("t2 pos wrap", pos, posExp(8'd254));
    @(negedge clk);

    // Zero-step command
    applyStimulus(1'b1, 8'd0);
    monitorCommand("t3", 1'b1, 0, 8'd254, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    checkOutput("t3 done off", 8'(done), 8'd0);
    checkOutput("t3 ab",       8'({enc_a, enc_b}), 8'd0);
    checkOutput("t3 pos",      pos, posExp(8'd254));

    // Running command with a second one held pending on cmd_valid
    applyStimulus(1'b0, 8'd1);
    monitorCommand("t4a", 1'b0, 1, 8'd254, 1'b1, 1'b1, 8'd2);
    monitorCommand("t4b", 1'b1, 2, 8'd253, 1'b0, 1'b0, 8'd0);
    checkOutput("t4 pos end", pos, posExp(8'd255));
    @(negedge clk);

    // Reset in the middle of a five-step command
    applyStimulus(1'b1, 8'd5);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t5 c6 ab",   8'({enc_a, enc_b}), 8'b10);
    checkOutput("t5 c6 busy", 8'(busy), 8'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5 rst ab",    8'({enc_a, enc_b}), 8'd0);
    checkOutput("t5 rst busy",  8'(busy), 8'd0);
    checkOutput("t5 rst done",  8'(done), 8'd0);
    checkOutput("t5 rst pos",   pos, 8'd0);
    checkOutput("t5 rst ready", 8'(cmd_if.cmd_ready), 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t5 post c%0d ab", c),   8'({enc_a, enc_b}), 8'd0);
      checkOutput($sformatf("t5 post c%0d busy", c), 8'(busy), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
